dma_engine: RTL

// - Consumes dma_instruction words from instruction_queue (out_dma_instr) and performs single-word transfers.
// - Each word is moved either main memory -> cache slot (mem_we=0) or cache slot -> main memory (mem_we=1).
// - Sits directly downstream of the queue. Buffers instructions in a small FIFO, asserts stall so the

---
 rtl/dma_engine_pkg.sv | 33 +++
 rtl/dma_engine_fifo.sv | 63 ++++++
 rtl/dma_engine.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dma_engine_pkg.sv
// Shared types for the DMA engine slice.
//   dma_instruction : one queued transfer request, {valid, mem_we, main_mem_addr, cache_slot, cache_addr}
//   dma_state_t     : transfer FSM states
//   first_state()   : state entered when an instruction is popped
package dma_engine_pkg;

   typedef struct packed {
      logic        valid;
      logic        mem_we;
      logic [6:0]  main_mem_addr;
      logic [1:0]  cache_slot;
      logic [10:0] cache_addr;
   } dma_instruction;

   localparam int DMA_INSTR_W   = $bits(dma_instruction);
   // The valid bit is implied by FIFO occupancy, so it is not stored.
   localparam int DMA_PAYLOAD_W = DMA_INSTR_W - 1;

   typedef enum logic [2:0] {
      IDLE,
      MEM_RD,
      CACHE_WR,
      CACHE_RD,
      CACHE_WAIT,
      MEM_WR
   } dma_state_t;

   // Loads start on the memory side, stores start on the cache side.
   function automatic dma_state_t first_state(input logic mem_we);
      return mem_we ? CACHE_RD : MEM_RD;
   endfunction

endpackage

// File: rtl/dma_engine_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count.
//   clk, reset : clock, asynchronous active-high reset (empties the FIFO)
//   push, din  : write request and data; accepted when not full or when popping the same cycle
//   pop, dout  : read request and head-of-queue data (dout is valid whenever empty=0)
//   count      : number of stored entries, 0..DEPTH
//   full/empty : occupancy flags derived from count
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop && !empty;
      // A full FIFO still accepts a word when the head leaves in the same cycle.
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      count_d  = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push) mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/dma_engine.sv
// dma_engine: executes dma_instruction words in order, one word per instruction.
//   Loads move main memory -> cache slot, stores move cache slot -> main memory.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   in_dma_instr               : instruction from the queue, captured when valid=1
//   stall                      : asks the queue to drop re (count >= FIFO_DEPTH-STALL_MARGIN)
//   mem_req/we/addr/wdata      : main-memory request, held until mem_ack
//   mem_ack, mem_rdata         : request completion and read data (valid with mem_ack)
//   cache_re/we/slot/addr/wdata: cache strobes, one cycle each
//   cache_rdata                : cache read data, valid the cycle after cache_re
//   busy                       : FSM active or instructions pending
//   overflow                   : sticky, an instruction was dropped on a full FIFO
module dma_engine
   import dma_engine_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int FIFO_DEPTH   = 4,
   parameter int STALL_MARGIN = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  dma_instruction    in_dma_instr,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [6:0]        mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              cache_re,
   output logic              cache_we,
   output logic [1:0]        cache_slot,
   output logic [10:0]       cache_addr,
   output logic [DATA_W-1:0] cache_wdata,
   input  logic [DATA_W-1:0] cache_rdata,
   output logic              busy,
   output logic              overflow
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [DMA_PAYLOAD_W-1:0] fifo_dout;
   logic [CNT_W-1:0]         fifo_count;
   logic                     fifo_full, fifo_empty, fifo_pop;
   dma_instruction           head;

   dma_state_t  state_q, state_d;
   logic [6:0]  cur_addr_q, cur_addr_d;
   logic [1:0]  cur_slot_q, cur_slot_d;
   logic [10:0] cur_cache_addr_q, cur_cache_addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic        overflow_q, overflow_d;

   sync_fifo #(
      .WIDTH (DMA_PAYLOAD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (in_dma_instr.valid),
      .pop   (fifo_pop),
      .din   (in_dma_instr[DMA_PAYLOAD_W-1:0]),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign head     = {1'b1, fifo_dout};
   assign fifo_pop = (state_q == IDLE) && !fifo_empty;
   // Registered count plus margin covers the queue's one-cycle re latency.
   assign stall    = (fifo_count >= CNT_W'(FIFO_DEPTH - STALL_MARGIN));
   assign busy     = (state_q != IDLE) || !fifo_empty;
   assign overflow = overflow_q;

   always_comb begin
      overflow_d = overflow_q;
      if (in_dma_instr.valid && fifo_full && !fifo_pop) overflow_d = 1'b1;
   end

   always_comb begin
      state_d          = state_q;
      cur_addr_d       = cur_addr_q;
      cur_slot_d       = cur_slot_q;
      cur_cache_addr_d = cur_cache_addr_q;
      data_d           = data_q;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               cur_addr_d       = head.main_mem_addr;
               cur_slot_d       = head.cache_slot;
               cur_cache_addr_d = head.cache_addr;
               state_d          = first_state(head.mem_we);
            end
         end
         MEM_RD: begin
            if (mem_ack) begin
               data_d  = mem_rdata;
               state_d = CACHE_WR;
            end
         end
         CACHE_WR:   state_d = IDLE;
         CACHE_RD:   state_d = CACHE_WAIT;
         CACHE_WAIT: begin
            data_d  = cache_rdata;
            state_d = MEM_WR;
         end
         MEM_WR: begin
            if (mem_ack) state_d = IDLE;
         end
         default:    state_d = IDLE;
      endcase
   end

   // Strobes decode the state register directly; an async reset therefore
   // drops them immediately. Address/data are forced to 0 while their strobe is low.
   always_comb begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      cache_re    = 1'b0;
      cache_we    = 1'b0;
      cache_slot  = '0;
      cache_addr  = '0;
      cache_wdata = '0;
      case (state_q)
         MEM_RD: begin
            mem_req  = 1'b1;
            mem_addr = cur_addr_q;
         end
         MEM_WR: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = cur_addr_q;
            mem_wdata = data_q;
         end
         CACHE_RD: begin
            cache_re   = 1'b1;
            cache_slot = cur_slot_q;
            cache_addr = cur_cache_addr_q;
         end
         CACHE_WR: begin
            cache_we    = 1'b1;
            cache_slot  = cur_slot_q;
            cache_addr  = cur_cache_addr_q;
            cache_wdata = data_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         cur_addr_q       <= '0;
         cur_slot_q       <= '0;
         cur_cache_addr_q <= '0;
         data_q           <= '0;
         overflow_q       <= 1'b0;
      end else begin
         state_q          <= state_d;
         cur_addr_q       <= cur_addr_d;
         cur_slot_q       <= cur_slot_d;
         cur_cache_addr_q <= cur_cache_addr_d;
         data_q           <= data_d;
         overflow_q       <= overflow_d;
      end
   end

endmodule
